// File: rtl/sp_ram_arbiter_pkg.sv
// Shared constants for the single-port RAM arbiter: requester ids,
// command encoding and default widths.
package sp_ram_pkg;

  localparam int DATA_W_DEF     = 4;
  localparam int ADDR_W_DEF     = 4;
  localparam int TURNAROUND_DEF = 1;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // Bit 0 drives the RAM read enable and bit 1 the write enable.
  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RD   = 2'b01,
    CMD_WR   = 2'b10
  } cmd_e;

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational.
// On advance, the pointer moves to the requester that did not just win.
module rr_arb2
  import sp_ram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt_valid,
  output logic gnt_id
);

  logic ptr;

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = REQ_M0;
    if (req0 && req1) gnt_id = ptr;
    else if (req1)    gnt_id = REQ_M1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= REQ_M0;
    else if (advance) ptr <= ~gnt_id;
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port registered-read RAM between two requesters.
// Uses round-robin arbitration, a registered command stage and a read-to-write turnaround bubble.
module sp_ram_arbiter
  import sp_ram_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TURNAROUND = TURNAROUND_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  input  logic              m1_valid,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              gnt_valid;
  logic              gnt_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              stall;
  logic              accept;
  cmd_e              cmd_next;
  cmd_e              cmd_q;
  logic              cmd_id;
  logic              tag_valid;
  logic              tag_id;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (m0_valid),
    .req1      (m1_valid),
    .advance   (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    win_we    = m0_we;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (gnt_id == REQ_M1) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  // The shared data pins need a dead cycle between the previous read and a write.
  // The stalled write keeps its grant because the pointer does not move.
  assign stall  = (TURNAROUND != 0) && ram_rd_en && gnt_valid && win_we;
  assign accept = gnt_valid && !stall;

  assign m0_ready = accept && (gnt_id == REQ_M0);
  assign m1_ready = accept && (gnt_id == REQ_M1);

  always_comb begin
    cmd_next = CMD_IDLE;
    if (accept) cmd_next = win_we ? CMD_WR : CMD_RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= CMD_IDLE;
      cmd_id    <= REQ_M0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag_valid <= 1'b0;
      tag_id    <= REQ_M0;
    end else begin
      cmd_q     <= cmd_next;
      tag_valid <= ram_rd_en;
      tag_id    <= cmd_id;
      if (accept) begin
        cmd_id    <= gnt_id;
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
      end
    end
  end

  assign ram_rd_en = (cmd_q == CMD_RD);
  assign ram_wr_en = (cmd_q == CMD_WR);

  // The RAM read buffer is valid one cycle after the read strobe, so responses line up with the tag.
  assign m0_rsp_valid = tag_valid && (tag_id == REQ_M0);
  assign m1_rsp_valid = tag_valid && (tag_id == REQ_M1);
  assign m0_rsp_rdata = ram_rdata;
  assign m1_rsp_rdata = ram_rdata;

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Shares one single-port synchronous RAM (DATA_W x 2^ADDR_W, registered read, one port for both read and write) between two requesters, m0 and m1.
- Arbitrates with two-way round-robin and registers the winning command onto the RAM control and address pins.
- Routes registered read data back to the requester that issued the read.
- Inserts a bus-turnaround bubble between a read and a following write, because the RAM data pins are shared for read and write.

Parameters:
- DATA_W, 4, RAM word width.
- ADDR_W, 4, RAM address width; depth is 2^ADDR_W.
- TURNAROUND, 1, idle RAM cycles forced between a read command and a following write command (0 or 1).

Ports:
- clk  in  1  single clock; all flops on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_valid / m1_valid  in  1  request present.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  word address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_ready / m1_ready  out  1  request accepted this cycle (combinational).
- m0_rsp_valid / m1_rsp_valid  out  1  read data valid, one-cycle pulse.
- m0_rsp_rdata / m1_rsp_rdata  out  DATA_W  read data; meaningful only while the matching rsp_valid is high.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_wr_en  out  1  registered RAM write enable.
- ram_rd_en  out  1  registered RAM read enable.
- ram_rdata  in  DATA_W  RAM read buffer output, valid the cycle after ram_rd_en is sampled.

Behaviour:
- Reset (async assert, sync release): ram_wr_en=0, ram_rd_en=0, ram_addr=0, ram_wdata=0, rsp_valid both 0, rr pointer=m0, read tag=0, turnaround flag=0.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester named by the rr pointer wins.
  - After every accepted request the pointer moves to the other requester. With no accept, the pointer holds.
- Handshake: mX_ready=1 only for the winner, and only if it is not stalled. A transfer occurs when valid&&ready at a posedge. The requester must hold valid, we, addr and wdata stable until accepted. The loser's ready is 0.
- Stall: when TURNAROUND=1, the RAM command registered in the previous cycle was a read (ram_rd_en=1), and the winner is a write:
  - ready=0 for both requesters.
  - The command register loads idle (wr_en=rd_en=0).
  - The rr pointer does not move.
  - The same write wins next cycle, unless a read from the other requester holds priority; a read is never stalled.
- Command stage: on accept at edge E, the ram_* outputs take the winner's command at E and are held for exactly one cycle. With no accept, wr_en=rd_en=0, while addr and wdata keep their last value.
- Read latency:
  - Accept at edge E, so ram_rd_en is high in cycle E..E+1 and the RAM samples it at E+1.
  - At E+1 the controller registers rsp tag = {valid, id}.
  - mX_rsp_valid is high in cycle E+1..E+2 for the tagged id only, and mX_rsp_rdata = ram_rdata combinationally. Both rsp_rdata ports carry ram_rdata.
  - Total: 2 cycles from accept to response. Back-to-back reads give back-to-back responses in order.
- Writes: complete at RAM edge E+1. There is no write response.
- Throughput:
  - One command per cycle.
  - Read→write costs one bubble when TURNAROUND=1.
  - Write→read and same-type sequences have no bubble.
- Reset mid-operation: pending command and response are dropped. No rsp_valid is asserted after reset release for a pre-reset read.
- Same-address write then read on consecutive accepts returns the new data (the RAM write lands before the read sample).

Decomposition:
- Package sp_ram_pkg holds:
  - the requester-id constants REQ_M0=1'b0 and REQ_M1=1'b1;
  - the command-type encoding CMD_IDLE/CMD_RD/CMD_WR (2 bits);
  - the default widths.
- Sub-module rr_arb2: a two-way round-robin arbiter with a pointer flop and an advance input. Grant is combinational from the two requests and the pointer; the pointer updates on advance.

Test Plan:
- Single write then read: m0 writes addr 3 data 0xA, then reads addr 3 → m0_rsp_valid exactly 2 cycles after the read accept with rdata 0xA. m1_rsp_valid stays 0.
- Contention: m0 and m1 both held valid with reads of addr 1 and addr 2 for 4 cycles → grants alternate m0,m1,m0,m1. Responses return in the same order with the correct data per id.
- Turnaround: m0 reads addr 5 at edge E, m1 write pending at E+1 → m1_ready=0 and ram_wr_en=0 in that cycle. The write is accepted at E+2. With TURNAROUND=0, it is accepted at E+1.
- Write→read same address back-to-back: m1 writes addr 7 = 0x6, m0 reads addr 7 next cycle → rdata 0x6.
- Reset mid-read: assert rst_n=0 one cycle after a read accept → all ram_* and rsp_valid go 0 immediately. No response after release, and the rr pointer returns to m0.
- Idle: no valid for 10 cycles → ram_wr_en and ram_rd_en stay 0, ready stays 0, and the pointer is unchanged.
